// File: rtl/sprite_motion_sequencer.sv
// Purpose: on each vsync rising edge, bounce two sprites by their velocities and write {y,x} to the sprite peripheral.
// Latency: sprite 0 write visible two cycles after the edge is sampled, sprite 1 two cycles later, idle after five.
// Backpressure: none; a vsync edge arriving mid-sequence is dropped and recorded in sticky overrun.
module sprite_motion_sequencer #(
    parameter int         X_MAX     = 244,
    parameter int         Y_MAX     = 180,
    parameter logic [5:0] SPR0_ADDR = 6'h04,
    parameter logic [5:0] SPR1_ADDR = 6'h1A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vsync_in,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [15:0] cfg_pos,
    input  logic [7:0]  cfg_vel,
    input  logic        ovr_clr,
    output logic [5:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic        busy,
    output logic [7:0]  frame_cnt,
    output logic        overrun
);
    // Field order matches {cfg_pos, cfg_vel} so a config word maps straight onto a sprite.
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [3:0] vy;
        logic [3:0] vx;
    } spr_t;

    typedef enum logic [2:0] {IDLE, CALC0, WR0, CALC1, WR1} state_t;

    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    state_t state;
    spr_t   spr0, spr1;
    spr_t   cfg_spr, nxt0, nxt1;
    logic   vs_q;
    logic   vs_edge;

    // -8 has no positive twin in 4 bits, so the reversal saturates to +7.
    function automatic logic [3:0] neg_vel(input logic [3:0] v);
        return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
    endfunction

    function automatic logic [11:0] axis_step(input logic [7:0] p, input logic [3:0] v,
                                              input logic [7:0] lim);
        logic signed [9:0] s;
        s = $signed({2'b00, p}) + $signed({{6{v[3]}}, v});
        if (s < 10'sd0)
            return {neg_vel(v), 8'd0};
        else if (s > $signed({2'b00, lim}))
            return {neg_vel(v), lim};
        else
            return {v, s[7:0]};
    endfunction

    function automatic spr_t spr_step(input spr_t s);
        spr_t n;
        {n.vx, n.x} = axis_step(s.x, s.vx, X_LIM);
        {n.vy, n.y} = axis_step(s.y, s.vy, Y_LIM);
        return n;
    endfunction

    assign cfg_spr = {cfg_pos, cfg_vel};
    assign vs_edge = vsync_in & ~vs_q;

    // A config load landing on the sprite's own CALC cycle replaces the computed update.
    always_comb begin
        nxt0 = (cfg_we && !cfg_sel) ? cfg_spr : spr_step(spr0);
        nxt1 = (cfg_we &&  cfg_sel) ? cfg_spr : spr_step(spr1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            spr0        <= '0;
            spr1        <= '0;
            vs_q        <= 1'b1;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_write_n <= 2'b11;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            overrun     <= 1'b0;
        end else begin
            vs_q <= vsync_in;

            if (vs_edge && enable && state != IDLE)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            if (cfg_we && !cfg_sel)
                spr0 <= cfg_spr;
            if (cfg_we && cfg_sel)
                spr1 <= cfg_spr;

            case (state)
                IDLE: begin
                    bus_write_n <= 2'b11;
                    if (vs_edge && enable) begin
                        state <= CALC0;
                        busy  <= 1'b1;
                    end
                end
                CALC0: begin
                    spr0        <= nxt0;
                    bus_write_n <= 2'b01;
                    bus_addr    <= SPR0_ADDR;
                    bus_wdata   <= {16'h0, nxt0.y, nxt0.x};
                    state       <= WR0;
                end
                WR0: begin
                    bus_write_n <= 2'b11;
                    state       <= CALC1;
                end
                CALC1: begin
                    spr1        <= nxt1;
                    bus_write_n <= 2'b01;
                    bus_addr    <= SPR1_ADDR;
                    bus_wdata   <= {16'h0, nxt1.y, nxt1.x};
                    state       <= WR1;
                end
                WR1: begin
                    bus_write_n <= 2'b11;
                    busy        <= 1'b0;
                    frame_cnt   <= frame_cnt + 8'd1;
                    state       <= IDLE;
                end
                default: begin
                    bus_write_n <= 2'b11;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
